// File: rtl/tx_fifo_pkg.sv
// tx_fifo_pkg: shared definitions for the transmit frame FIFO controller.
//   - field offsets inside the 40-bit TX RAM word
//   - write-side FSM state encoding
//   - pack_word(): builds a RAM word from host-side fields
package tx_fifo_pkg;

  localparam int DATA_LSB = 0;
  localparam int BE_LSB   = 32;
  localparam int SOF_BIT  = 36;
  localparam int EOF_BIT  = 37;

  localparam int WORD_W   = 40;
  // Only the low 38 bits carry information; the top two are always zero.
  localparam int SKID_W   = 38;

  typedef enum logic [1:0] {
    WS_IDLE  = 2'd0,
    WS_FRAME = 2'd1,
    WS_DROP  = 2'd2
  } wr_state_e;

  function automatic logic [WORD_W-1:0] pack_word(input logic [31:0] data,
                                                  input logic [3:0]  be,
                                                  input logic        sof,
                                                  input logic        eof);
    pack_word = {2'b00, eof, sof, be, data};
  endfunction

endpackage

// File: rtl/tx_fifo_skid.sv
// tx_fifo_skid: 2-entry valid/ready skid buffer on the RAM read path.
// Ports:
//   gclk, grst        clock, synchronous active-high reset
//   flush             drop all entries and ignore this cycle's push
//   push, push_data   word arriving from the 1-clk RAM read pipeline
//   pop               consumer took the head word (only when out_valid)
//   out_valid/data    head entry
//   cnt               occupancy, used upstream to throttle reads
// The producer never pushes into a full buffer: reads are only issued when
// occupancy plus in-flight reads leaves room, so there is no in_ready.
module tx_fifo_skid
  import tx_fifo_pkg::*;
#(
  parameter int W = SKID_W
) (
  input  logic         gclk,
  input  logic         grst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   cnt
);

  logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [1:0]   c;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    c      = cnt_q;
    if (flush) begin
      c = 2'd0;
    end else begin
      // Pop first so a simultaneous push lands in the slot just vacated.
      if (pop) begin
        ent0_d = ent1_q;
        c      = c - 2'd1;
      end
      if (push) begin
        if (c == 2'd0) ent0_d = push_data;
        else           ent1_d = push_data;
        c = c + 2'd1;
      end
    end
    cnt_d = c;
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = ent0_q;
  assign cnt       = cnt_q;

endmodule

// File: rtl/tx_fifo_ctrl.sv
// tx_fifo_ctrl: store-and-forward frame FIFO controller for the 2^TABITS x 40
// transmit RAM (RAM is external). The MAC only ever sees committed frames.
// Ports:
//   gclk, grst                    clock, synchronous active-high reset
//   wr_valid/ready/data/be/eof    host write stream; wr_abort drops the frame
//   wr_ovf                        one-cycle pulse when a frame exceeds the RAM
//   ram_we_n/waddr/wdata          RAM write port (active-low enable)
//   ram_raddr/rdata               RAM read port, rdata valid 1 clk after raddr
//   rd_valid/ready/data/be/sof/eof  MAC read stream
//   rd_retry                      (TX_FIFO_RETRY_EN only) replay current frame
//   frm_count, free_words, almost_full  status
// Build option: define TX_FIFO_RETRY_EN for half-duplex collision retry. Space
// is then released per frame (on the eof pop) instead of per word.
module tx_fifo_ctrl
  import tx_fifo_pkg::*;
#(
  parameter int TABITS       = 12,
  parameter int AFULL_MARGIN = 16
) (
  input  logic              gclk,
  input  logic              grst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_be,
  input  logic              wr_eof,
  input  logic              wr_abort,
  output logic              wr_ovf,
  output logic              ram_we_n,
  output logic [TABITS-1:0] ram_waddr,
  output logic [39:0]       ram_wdata,
  output logic [TABITS-1:0] ram_raddr,
  input  logic [39:0]       ram_rdata,
  output logic              rd_valid,
  input  logic              rd_ready,
`ifdef TX_FIFO_RETRY_EN
  input  logic              rd_retry,
`endif
  output logic [31:0]       rd_data,
  output logic [3:0]        rd_be,
  output logic              rd_sof,
  output logic              rd_eof,
  output logic [TABITS:0]   frm_count,
  output logic [TABITS:0]   free_words,
  output logic              almost_full
);

  localparam int PW = TABITS + 1;
  localparam logic [PW-1:0] MAX_FREE = PW'((1 << TABITS) - 1);
  localparam logic [PW-1:0] AF_LIM   = PW'(AFULL_MARGIN);

  wr_state_e     state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  // wr_base is both the start of the frame being written and the end of the
  // committed region, which is exactly where the read side must stop.
  logic [PW-1:0] wr_base_q, wr_base_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;       // next RAM word to fetch
  logic [PW-1:0] rd_pop_ptr_q, rd_pop_ptr_d; // RAM address of the skid head
  logic [PW-1:0] frm_count_q, frm_count_d;
  logic [PW-1:0] rd_free_ptr;
  logic          wr_ovf_q, wr_ovf_d;
  logic          inflight_q, inflight_d;
  logic          rst_done_q;

  logic          full, accept, wr_en, wr_sof, commit;
  logic          pop, eof_pop, issue, retry_fire;
  logic [2:0]    occ;
  logic [1:0]    skid_cnt;
  logic [SKID_W-1:0] skid_out;
  logic          unused_rdata;

  assign unused_rdata = ^ram_rdata[WORD_W-1:SKID_W];

  // ---------------------------------------------------------------- space
  assign free_words  = MAX_FREE - (wr_ptr_q - rd_free_ptr);
  assign almost_full = (free_words < AF_LIM);
  assign full        = (free_words == '0);
  assign frm_count   = frm_count_q;

  // DROP keeps accepting so the host can flush the oversize tail.
  assign wr_ready = rst_done_q & ((state_q == WS_DROP) | ~full);
  assign accept   = wr_valid & wr_ready;
  assign wr_ovf   = wr_ovf_q;

  // ---------------------------------------------------------- write FSM
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    wr_base_d = wr_base_q;
    wr_en     = 1'b0;
    wr_sof    = 1'b0;
    commit    = 1'b0;
    wr_ovf_d  = 1'b0;
    case (state_q)
      WS_IDLE: begin
        if (accept && !wr_abort) begin
          wr_en     = 1'b1;
          wr_sof    = 1'b1;
          wr_ptr_d  = wr_ptr_q + PW'(1);
          wr_base_d = wr_ptr_q;
          if (wr_eof) begin
            commit    = 1'b1;
            wr_base_d = wr_ptr_q + PW'(1);
          end else begin
            state_d = WS_FRAME;
          end
        end
      end
      WS_FRAME: begin
        // Full with nothing committed: the frame alone fills the RAM and
        // can never complete, so give its space back and swallow the rest.
        if (full && frm_count_q == '0) begin
          wr_ptr_d = wr_base_q;
          wr_ovf_d = 1'b1;
          state_d  = WS_DROP;
        end else if (accept) begin
          if (wr_abort) begin
            wr_ptr_d = wr_base_q;
            state_d  = WS_IDLE;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (wr_eof) begin
              commit    = 1'b1;
              wr_base_d = wr_ptr_q + PW'(1);
              state_d   = WS_IDLE;
            end
          end
        end
      end
      WS_DROP: begin
        if (accept && (wr_eof || wr_abort)) state_d = WS_IDLE;
      end
      default: state_d = WS_IDLE;
    endcase
  end

  assign ram_we_n  = ~wr_en;
  assign ram_waddr = wr_ptr_q[TABITS-1:0];
  assign ram_wdata = wr_en ? pack_word(wr_data, wr_be, wr_sof, wr_eof) : '0;

  // ----------------------------------------------------------- read side
  assign pop     = rd_valid & rd_ready;
  assign eof_pop = pop & rd_eof;

`ifdef TX_FIFO_RETRY_EN
  logic [PW-1:0] rd_free_ptr_q, rd_free_ptr_d;
  assign retry_fire    = rd_retry & ~eof_pop;
  // Space is held until the whole frame has left, so a retry can replay it.
  assign rd_free_ptr_d = eof_pop ? rd_pop_ptr_q + PW'(1) : rd_free_ptr_q;
  assign rd_free_ptr   = rd_free_ptr_q;
  always_ff @(posedge gclk) begin
    if (grst) rd_free_ptr_q <= '0;
    else      rd_free_ptr_q <= rd_free_ptr_d;
  end
`else
  assign retry_fire  = 1'b0;
  assign rd_free_ptr = rd_pop_ptr_q;
`endif

  // Words the skid will hold next cycle before any new issue lands.
  assign occ   = {1'b0, skid_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = ~retry_fire & (frm_count_q != '0) & (rd_ptr_q != wr_base_q)
               & (occ < 3'd2);

  always_comb begin
    rd_ptr_d     = rd_ptr_q + PW'(issue);
    rd_pop_ptr_d = rd_pop_ptr_q + PW'(pop);
    inflight_d   = issue;
    frm_count_d  = frm_count_q + PW'(commit) - PW'(eof_pop);
    if (retry_fire) begin
      // Frame start is the free pointer: nothing of this frame is released.
      rd_ptr_d     = rd_free_ptr;
      rd_pop_ptr_d = rd_free_ptr;
    end
  end

  assign ram_raddr = rd_ptr_q[TABITS-1:0];

  tx_fifo_skid #(.W(SKID_W)) u_skid (
    .gclk      (gclk),
    .grst      (grst),
    .flush     (retry_fire),
    .push      (inflight_q),
    .push_data (ram_rdata[SKID_W-1:0]),
    .pop       (pop),
    .out_valid (rd_valid),
    .out_data  (skid_out),
    .cnt       (skid_cnt)
  );

  assign rd_data = skid_out[DATA_LSB +: 32];
  assign rd_be   = skid_out[BE_LSB +: 4];
  assign rd_sof  = skid_out[SOF_BIT];
  assign rd_eof  = skid_out[EOF_BIT];

  // ----------------------------------------------------------- registers
  always_ff @(posedge gclk) begin
    if (grst) begin
      state_q      <= WS_IDLE;
      wr_ptr_q     <= '0;
      wr_base_q    <= '0;
      rd_ptr_q     <= '0;
      rd_pop_ptr_q <= '0;
      frm_count_q  <= '0;
      wr_ovf_q     <= 1'b0;
      inflight_q   <= 1'b0;
      rst_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_base_q    <= wr_base_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_pop_ptr_q <= rd_pop_ptr_d;
      frm_count_q  <= frm_count_d;
      wr_ovf_q     <= wr_ovf_d;
      inflight_q   <= inflight_d;
      rst_done_q   <= 1'b1;
    end
  end

endmodule
